// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Purpose : Clock constants and default divisors shared by the ticker slice.
// Revision: 1.0
// ============================================================================
package clk_div_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int CNT_W_DEF = 27;
    localparam int MAX_CH    = 16;
    localparam int MAX_W     = 32;

    localparam int DIV_120HZ = 416_667;
    localparam int DIV_60HZ  = 833_333;
    localparam int DIV_1S    = 50_000_000;
    localparam int DIV_2S    = 100_000_000;

    typedef logic [3:0] ch_idx_t;

    function automatic logic [MAX_W-1:0] def_div_at(input int ch);
        case (ch % 4)
            0:       return MAX_W'(DIV_120HZ);
            1:       return MAX_W'(DIV_60HZ);
            2:       return MAX_W'(DIV_1S);
            default: return MAX_W'(DIV_2S);
        endcase
    endfunction

    // Packs the four default rates, repeating every fourth channel, at cnt_w spacing.
    function automatic logic [MAX_CH*MAX_W-1:0] default_div_vec(input int cnt_w);
        logic [MAX_CH*MAX_W-1:0] v;
        logic [MAX_W-1:0]        d;
        v = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            d = def_div_at(i);
            for (int b = 0; b < cnt_w && b < MAX_W; b++) begin
                if (i * cnt_w + b < MAX_CH * MAX_W) begin
                    v[i*cnt_w+b] = d[b];
                end
            end
        end
        return v;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/multi_rate_ticker_tick_channel.sv
`default_nettype none
// ============================================================================
// Module  : tick_channel
// Purpose : One rate channel: divisor register, period counter, tick and sq.
// Revision: 1.0
// ============================================================================
module tick_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sclr_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_div_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] w_term;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // A zero divisor behaves as one, so the terminal count can never underflow.
    assign w_term = ((div_q == '0) ? CNT_W'(1) : div_q) - CNT_W'(1);
    // >= recovers a counter left above a divisor shrunk while disabled.
    assign wrap_o = en_i && (cnt_q >= w_term);

    always_comb begin
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        div_d  = ld_i ? ld_div_i : div_q;
        if (sclr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (wrap_o) begin
            cnt_d  = '0;
            sq_d   = ~sq_q;
            tick_d = 1'b1;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule : tick_channel
`default_nettype wire

// File: rtl/multi_rate_ticker.sv
`default_nettype none
// ============================================================================
// Module  : multi_rate_ticker
// Purpose : N_CH independent tick/square-wave dividers with a one-deep divisor write slot.
// Revision: 1.0
// ============================================================================
module multi_rate_ticker
    import clk_div_pkg::*;
#(
    parameter int                      N_CH    = 4,
    parameter int                      CNT_W   = CNT_W_DEF,
    parameter logic [N_CH*CNT_W-1:0]   DEF_DIV = (N_CH*CNT_W)'(default_div_vec(CNT_W))
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sclr,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    logic             pend_vld_q, pend_vld_d;
    ch_idx_t          pend_ch_q,  pend_ch_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;

    logic [N_CH-1:0]  w_wrap;
    logic [N_CH-1:0]  w_apply;
    logic             w_ch_ok;
    logic             w_accept;

    assign cfg_ready = ~pend_vld_q;
    assign w_ch_ok   = ({1'b0, cfg_ch} < 5'(N_CH));
    // Writes to channels that do not exist complete the handshake but never occupy the slot.
    assign w_accept  = cfg_valid && cfg_ready && w_ch_ok;

    always_comb begin
        pend_vld_d = pend_vld_q & ~(|w_apply);
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        if (w_accept) begin
            pend_vld_d = 1'b1;
            pend_ch_d  = cfg_ch;
            pend_div_d = cfg_div;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Load at period boundary, or at once when the channel is idle or being cleared.
        assign w_apply[i] = pend_vld_q && (pend_ch_q == 4'(i)) && (sclr || !en[i] || w_wrap[i]);

        tick_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (DEF_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i    (clock_in),
            .rst_ni   (reset_n),
            .en_i     (en[i]),
            .sclr_i   (sclr),
            .ld_i     (w_apply[i]),
            .ld_div_i (pend_div_q),
            .wrap_o   (w_wrap[i]),
            .tick_o   (tick[i]),
            .sq_o     (sq[i])
        );
    end

endmodule : multi_rate_ticker
`default_nettype wire

// File: tb/tb_multi_rate_ticker.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_rate_ticker
// Purpose : Scoreboard bench for multi_rate_ticker with short divisors {20,10,5,4}.
// Revision: 1.0
// ============================================================================
module tb_multi_rate_ticker;

    localparam int CNT_W = 27;
    localparam logic [4*CNT_W-1:0] TB_DIV = {27'd20, 27'd10, 27'd5, 27'd4};

    typedef struct packed {
        logic [3:0] tick;
        logic [3:0] sq;
        logic       rdy;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [3:0]       en = '0;
    logic             sclr = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [3:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic [3:0]       tick;
    logic [3:0]       sq;

    obs_t exp_q[$];
    obs_t exp_r;
    obs_t obs_r;
    obs_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    multi_rate_ticker #(
        .N_CH    (4),
        .CNT_W   (CNT_W),
        .DEF_DIV (TB_DIV)
    ) dut (
        .clock_in  (clk),
        .reset_n   (reset_n),
        .en        (en),
        .sclr      (sclr),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en        = '0;
        sclr      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
    endtask

    // Reset is released 1 time unit after an edge; the next edge is enabled edge 1.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Expected outputs j enabled edges after a clean start with periods p0..p3.
    function automatic obs_t exp_periodic(input int j, input int p0, input int p1,
                                          input int p2, input int p3, input logic rdy);
        obs_t r;
        int   p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        r.rdy  = rdy;
        r.tick = '0;
        r.sq   = '0;
        for (int i = 0; i < 4; i++) begin
            r.tick[i] = (j % p[i] == 0);
            r.sq[i]   = ((j / p[i]) % 2 == 1);
        end
        return r;
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back('{tick: 4'h0, sq: 4'h0, rdy: 1'b1});
        exp_r = exp_q.pop_front();
        obs_r = {tick, sq, cfg_ready};
        n_chk++;
        if (obs_r !== exp_r) $display("FAIL reset_async got=%b want=%b (tick,sq,rdy)", obs_r, exp_r);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            en = 4'hF;
            exp_q.push_back('{tick: 4'h0, sq: 4'h0, rdy: 1'b1});
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL reset_hold k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
    endtask

    task automatic test_default_rates();
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 80; k++) begin
            exp_q.push_back(exp_periodic(k, 4, 5, 10, 20, 1'b1));
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL default_rates k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
    endtask

    task automatic test_cfg_apply();
        int nt;
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            cfg_valid = (k == 2);
            cfg_ch    = 4'd0;
            cfg_div   = 27'd7;
            nt = (k < 4) ? 0 : 1 + (k - 4) / 7;
            e = '{tick: 4'h0, sq: 4'h0, rdy: 1'b1};
            e.tick[0] = (k == 4) || (k > 4 && (k - 4) % 7 == 0);
            e.sq[0]   = (nt % 2 == 1);
            e.rdy     = !(k == 2 || k == 3);
            exp_q.push_back(e);
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL cfg_apply k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_div_zero_one();
        do_reset();
        en = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            cfg_valid = (k == 1 || k == 11);
            cfg_ch    = 4'd1;
            cfg_div   = (k == 1) ? 27'd0 : 27'd1;
            e = '{tick: 4'h0, sq: 4'h0, rdy: 1'b1};
            e.tick[1] = (k >= 5);
            e.sq[1]   = (k >= 5) && ((k - 4) % 2 == 1);
            e.rdy     = !((k >= 1 && k <= 4) || k == 11);
            exp_q.push_back(e);
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL div_zero_one k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_enable_gap();
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            en = (k >= 3 && k <= 5) ? 4'b0000 : 4'b0100;
            e = '{tick: 4'h0, sq: 4'h0, rdy: 1'b1};
            e.tick[2] = (k == 13 || k == 23);
            e.sq[2]   = (k >= 13 && k < 23);
            exp_q.push_back(e);
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL enable_gap k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
    endtask

    task automatic test_sclr();
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 30; k++) begin
            cfg_valid = (k == 5);
            cfg_ch    = 4'd0;
            cfg_div   = 27'd3;
            sclr      = (k == 8);
            if (k < 8)       e = exp_periodic(k, 4, 5, 10, 20, !(k >= 5));
            else if (k == 8) e = '{tick: 4'h0, sq: 4'h0, rdy: 1'b1};
            else             e = exp_periodic(k - 8, 3, 5, 10, 20, 1'b1);
            exp_q.push_back(e);
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL sclr k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
        sclr      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 13; k++) begin
            cfg_valid = 1'b0;
            cfg_ch    = 4'd9;
            cfg_div   = 27'd2;
            if (k <= 5 && k % 2 == 1) cfg_valid = 1'b1;
            if (k == 7) begin
                cfg_valid = 1'b1;
                cfg_ch    = 4'd3;
            end
            exp_q.push_back(exp_periodic(k, 4, 5, 10, 20, k < 7));
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL pre_reset k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
        cfg_valid = 1'b1;
        cfg_ch    = 4'd9;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back('{tick: 4'h0, sq: 4'h0, rdy: 1'b1});
        exp_r = exp_q.pop_front();
        obs_r = {tick, sq, cfg_ready};
        n_chk++;
        if (obs_r !== exp_r) $display("FAIL mid_reset_async got=%b want=%b (tick,sq,rdy)", obs_r, exp_r);
        else n_pass++;
        for (int r = 1; r <= 2; r++) begin
            exp_q.push_back('{tick: 4'h0, sq: 4'h0, rdy: 1'b1});
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL mid_reset_hold r=%0d got=%b want=%b (tick,sq,rdy)", r, obs_r, exp_r);
            else n_pass++;
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cfg_valid = (k % 2 == 0) && (k <= 10);
            cfg_ch    = 4'd9;
            exp_q.push_back(exp_periodic(k, 4, 5, 10, 20, 1'b1));
            step();
            exp_r = exp_q.pop_front();
            obs_r = {tick, sq, cfg_ready};
            n_chk++;
            if (obs_r !== exp_r) $display("FAIL post_reset k=%0d got=%b want=%b (tick,sq,rdy)", k, obs_r, exp_r);
            else n_pass++;
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_rates();
        test_cfg_apply();
        test_div_zero_one();
        test_enable_gap();
        test_sclr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_multi_rate_ticker
`default_nettype wire
